// File: rtl/inst_loader.sv
// Boot-time instruction loader: parses a LEN/payload/CSUM byte stream, writes
// 32-bit words into instruction memory and holds the core until a clean load.
module inst_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [2:0]            state_dbg
);

  // Stream handshake: a byte moves only in a cycle where in_valid && in_ready;
  // in_data is don't-care otherwise, and in_ready depends on state alone.

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state, state_nx;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [1:0]      byte_idx;
  logic [23:0]     word_buf;
  logic [7:0]      csum;
  logic [IW-1:0]   idle_cnt;
  logic            accept;
  logic            timed_out;
  logic            last_byte;
  logic            last_word;
  logic [16:0]     len_in;

  assign in_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CSUM);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign cpu_hold  = (state != S_DONE);
  assign state_dbg = state;

  assign accept    = in_valid && in_ready;
  assign len_in    = {1'b0, in_data, len_lo};
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = ((17'(words_loaded) + 17'd1) == {1'b0, len});
  // Fires on the TIMEOUT-th consecutive idle cycle of a counting state.
  assign timed_out = !accept && (idle_cnt == IW'(TIMEOUT - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_LEN_LO;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LEN_LO: if (accept) state_nx = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_in > (17'd1 << ADDR_WIDTH)) state_nx = S_ERR;
          else if (len_in == 17'd0)           state_nx = S_CSUM;
          else                                state_nx = S_DATA;
        end else if (timed_out) begin
          state_nx = S_ERR;
        end
      end
      S_DATA: begin
        if (accept && last_byte && last_word) state_nx = S_CSUM;
        else if (timed_out)                   state_nx = S_ERR;
      end
      S_CSUM: begin
        if (accept)         state_nx = (in_data == csum) ? S_DONE : S_ERR;
        else if (timed_out) state_nx = S_ERR;
      end
      S_DONE:  if (start) state_nx = S_LEN_LO;
      S_ERR:   if (start) state_nx = S_LEN_LO;
      default: state_nx = S_LEN_LO;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      len_lo       <= '0;
      len          <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      csum         <= '0;
      idle_cnt     <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_LEN_LO: begin
          idle_cnt <= '0;
          if (accept) len_lo <= in_data;
        end
        S_LEN_HI: begin
          if (accept) begin
            len      <= len_in[15:0];
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        S_DATA: begin
          if (accept) begin
            idle_cnt <= '0;
            csum     <= csum + in_data;
            byte_idx <= byte_idx + 2'd1;
            // The write for a completed word always goes out, whatever comes next.
            if (last_byte) begin
              mem_we       <= 1'b1;
              mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
              mem_wdata    <= {in_data, word_buf};
              words_loaded <= words_loaded + 1'b1;
            end else begin
              word_buf[byte_idx*8 +: 8] <= in_data;
            end
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        S_CSUM: begin
          if (accept) idle_cnt <= '0;
          else        idle_cnt <= idle_cnt + IW'(1);
        end
        S_DONE, S_ERR: begin
          if (start) begin
            words_loaded <= '0;
            csum         <= '0;
            idle_cnt     <= '0;
            byte_idx     <= '0;
          end
        end
        default: idle_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a frame-level model predicts memory writes
// and the final load outcome; one monitor checks every write strobe.
module tb_inst_loader;

  localparam int AW = 4;
  localparam int TO = 16;

  typedef logic [7:0] byte_q_t[$];

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;
  logic [2:0]    state_dbg;

  logic [AW+31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  inst_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Frame model: from the bytes actually delivered, predict writes and outcome
  // (0 = still loading, 1 = done, 2 = error).
  task automatic model_frame(input byte_q_t fr, output int exp_wl, output int outcome);
    int n, avail, nw;
    logic [7:0]  sum;
    logic [31:0] w;
    exp_wl = 0;
    outcome = 0;
    sum = 8'h00;
    if (fr.size() < 2) return;
    n = int'({fr[1], fr[0]});
    if (n > (1 << AW)) begin
      outcome = 2;
      return;
    end
    avail = fr.size() - 2;
    nw = (avail / 4 < n) ? avail / 4 : n;
    for (int i = 0; i < nw; i++) begin
      w = {fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]};
      exp_q.push_back({AW'(i), w});
    end
    for (int i = 0; i < avail && i < 4 * n; i++) sum = sum + fr[2+i];
    exp_wl = nw;
    if (avail > 4 * n) outcome = (fr[2+4*n] == sum) ? 1 : 2;
  endtask

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual=%0h:%08h expected=no write", mem_addr, mem_wdata);
        end else begin
          logic [AW+31:0] e;
          e = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin
            errors++;
            $display("FAIL write actual=%0h:%08h expected=%0h:%08h",
                     mem_addr, mem_wdata, e[AW+31:32], e[31:0]);
          end
        end
      end
      chk("excl_done_error", {62'd0, done, error} == 2'b11, 64'd0);
      chk("hold_vs_done", cpu_hold, !done);
      chk("ready_vs_status", in_ready, !(done || error));
    end
  end

  // ---------------- drivers ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data = 8'($urandom_range(0, 255));
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle_cycles(gap);
    in_valid = 1'b1;
    in_data = b;
    for (int t = 0; ; t++) begin
      if (in_ready) begin
        @(posedge sys_clk); #1;
        break;
      end
      if (t >= 20) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge sys_clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t fr, input int max_gap);
    foreach (fr[i]) send_byte(fr[i], $urandom_range(0, max_gap));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic check_end(input string name, input int exp_wl, input int outcome);
    idle_cycles(2);
    chk({name, "_done"}, done, outcome == 1);
    chk({name, "_error"}, error, outcome == 2);
    chk({name, "_hold"}, cpu_hold, outcome != 1);
    chk({name, "_ready"}, in_ready, outcome == 0);
    chk({name, "_words"}, words_loaded, exp_wl);
    chk({name, "_writes_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_hold"}, cpu_hold, 1);
    chk({name, "_ready"}, in_ready, 1);
    chk({name, "_we"}, mem_we, 0);
    chk({name, "_addr"}, mem_addr, 0);
    chk({name, "_wdata"}, mem_wdata, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_error"}, error, 0);
    chk({name, "_words"}, words_loaded, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    byte_q_t fr;
    int wl, oc;
    logic [7:0] s;

    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check_reset_values("reset");

    // Two-word load; payload sum 13+05+10+00+67+80+00+00 = 0x0F.
    fr = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h67, 8'h80, 8'h00, 8'h00, 8'h0F};
    model_frame(fr, wl, oc);
    chk("model_w0", exp_q[0], {4'h0, 32'h00100513});
    chk("model_w1", exp_q[1], {4'h1, 32'h00008067});
    chk("model_outcome", oc, 1);
    send_frame(fr, 0);
    check_end("good", wl, oc);
    chk("good_words_lit", words_loaded, 2);

    // Same frame, wrong checksum byte.
    pulse_start();
    fr[10] = 8'h4E;
    model_frame(fr, wl, oc);
    chk("model_bad_outcome", oc, 2);
    send_frame(fr, 0);
    check_end("badsum", wl, oc);

    // Oversize length: N = 17 > 2^4.
    pulse_start();
    fr = '{8'h11, 8'h00};
    model_frame(fr, wl, oc);
    send_frame(fr, 0);
    chk("oversize_error_now", error, 1);
    check_end("oversize", wl, oc);

    // Largest legal length: N = 16 fills the whole memory.
    pulse_start();
    fr = '{8'h10, 8'h00};
    s = 8'h00;
    for (int i = 0; i < 64; i++) begin
      fr.push_back(8'($urandom_range(0, 255)));
      s = s + fr[fr.size()-1];
    end
    fr.push_back(s);
    model_frame(fr, wl, oc);
    send_frame(fr, 0);
    check_end("full", wl, oc);
    chk("full_words_lit", words_loaded, 16);

    // Backpressure gaps below the timeout.
    pulse_start();
    fr = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h67, 8'h80, 8'h00, 8'h00, 8'h0F};
    model_frame(fr, wl, oc);
    send_frame(fr, TO - 4);
    check_end("gaps", wl, oc);

    // Stall after the 5th byte: 15 idle cycles survive, the 16th trips it.
    pulse_start();
    fr = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10};
    model_frame(fr, wl, oc);
    send_frame(fr, 0);
    idle_cycles(TO - 1);
    chk("stall15_error", error, 0);
    idle_cycles(1);
    chk("stall16_error", error, 1);
    check_end("timeout", 0, 2);

    // Empty load, then re-arm.
    pulse_start();
    fr = '{8'h00, 8'h00, 8'h00};
    model_frame(fr, wl, oc);
    send_frame(fr, 0);
    check_end("empty", wl, oc);
    pulse_start();
    chk("rearm_hold", cpu_hold, 1);
    chk("rearm_done", done, 0);
    chk("rearm_ready", in_ready, 1);
    chk("rearm_words", words_loaded, 0);

    // Reset after two payload bytes; no write may escape.
    fr = '{8'h02, 8'h00, 8'h13, 8'h05};
    send_frame(fr, 0);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    check_reset_values("midreset");

    // Fresh load from address 0 with start held high (ignored) until the checksum.
    fr = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h67, 8'h80, 8'h00, 8'h00, 8'h0F};
    model_frame(fr, wl, oc);
    start = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(fr[i], 0);
    start = 1'b0;
    send_byte(fr[10], 0);
    check_end("after_reset", wl, oc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
